// File: rtl/cmd_frame_sender_if.sv
// Command, UART byte and response signals between the test
// sequencer side and cmd_frame_sender.
interface cmd_frame_sender_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_payload;
  logic        cmd_expect_resp;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_timeout;

  modport master (
    output cmd_valid, cmd_opcode, cmd_payload,
    output cmd_expect_resp,
    output uart_tx_busy, uart_rx_valid, uart_rx_data,
    input  cmd_ready, uart_tx_en, uart_tx_data,
    input  resp_valid, resp_data, resp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_payload,
    input  cmd_expect_resp,
    input  uart_tx_busy, uart_rx_valid, uart_rx_data,
    output cmd_ready, uart_tx_en, uart_tx_data,
    output resp_valid, resp_data, resp_timeout
  );
endinterface

// File: rtl/cmd_frame_sender.sv
// Serialises opcode + LE payload frames into a byte UART and
// optionally gathers a little-endian response with timeout.
module cmd_frame_sender #(
  parameter int CLK_FREQ       = 25000000,
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int RESP_BYTES     = 4
) (
  input  logic              clk,
  input  logic              resetn,
  cmd_frame_sender_if.slave bus,
  output logic              busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] R_LAST = 3'(RESP_BYTES - 1);

  if (RESP_BYTES < 1 || RESP_BYTES > 4 ||
      TIMEOUT_CYCLES < 2 || CLK_FREQ < 1) begin : g_bad
    $error("cmd_frame_sender: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE, SEND, GAP, WAIT_RESP
  } state_t;

  state_t        state;
  logic [7:0]    op_q;
  logic [31:0]   pay_q;
  logic          exp_q;
  logic [2:0]    byte_idx;
  logic [2:0]    rx_idx;
  logic [TW-1:0] timer;
  logic [7:0]    frame_byte;

  assign bus.cmd_ready = (state == IDLE) && resetn;
  assign busy = (state != IDLE);

  always_comb begin
    frame_byte = pay_q[31:24];
    case (byte_idx)
      3'd0:    frame_byte = op_q;
      3'd1:    frame_byte = pay_q[7:0];
      3'd2:    frame_byte = pay_q[15:8];
      3'd3:    frame_byte = pay_q[23:16];
      default: frame_byte = pay_q[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      op_q             <= '0;
      pay_q            <= '0;
      exp_q            <= 1'b0;
      byte_idx         <= '0;
      rx_idx           <= '0;
      timer            <= '0;
      bus.uart_tx_en   <= 1'b0;
      bus.uart_tx_data <= '0;
      bus.resp_valid   <= 1'b0;
      bus.resp_data    <= '0;
      bus.resp_timeout <= 1'b0;
    end else begin
      bus.uart_tx_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q     <= bus.cmd_opcode;
            pay_q    <= bus.cmd_payload;
            exp_q    <= bus.cmd_expect_resp;
            byte_idx <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (!bus.uart_tx_busy) begin
            bus.uart_tx_en   <= 1'b1;
            bus.uart_tx_data <= frame_byte;
            state            <= GAP;
          end
        end
        GAP: begin
          if (byte_idx != 3'd4) begin
            byte_idx <= byte_idx + 3'd1;
            state    <= SEND;
          end else if (exp_q) begin
            rx_idx        <= '0;
            timer         <= '0;
            bus.resp_data <= '0;
            state         <= WAIT_RESP;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_RESP: begin
          // Stay one extra cycle so cmd_ready is low during the pulse
          if (bus.resp_valid || bus.resp_timeout) begin
            bus.resp_valid   <= 1'b0;
            bus.resp_timeout <= 1'b0;
            state            <= IDLE;
          end else if (bus.uart_rx_valid) begin
            bus.resp_data[{rx_idx[1:0], 3'b000} +: 8] <=
              bus.uart_rx_data;
            rx_idx <= rx_idx + 3'd1;
            timer  <= '0;
            if (rx_idx == R_LAST)
              bus.resp_valid <= 1'b1;
          end else if (timer == T_LAST) begin
            bus.resp_timeout <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cmd_frame_sender.md
Name: cmd_frame_sender

Overview:
Host-side initiator for the controller's serial command protocol, in synthesizable form for loopback and self-test builds. It accepts one command per handshake, serializes it as a 5-byte frame (opcode followed by a 32-bit little-endian payload) into a byte-level UART transmitter, and optionally collects a multi-byte little-endian response from a byte-level UART receiver, with a timeout. It sits between a test sequencer and uart_tool_tx/uart_tool_rx instances wired to the controller's rx/tx pins.

Parameters:
CLK_FREQ, 25000000, system clock in Hz (informational; used only to derive TIMEOUT_CYCLES default in wrappers)
TIMEOUT_CYCLES, 250000, idle cycles allowed between response bytes before abort (>=2)
RESP_BYTES, 4, response length in bytes, legal range 1..4

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_opcode  in  8  frame byte 0
cmd_payload  in  32  frame bytes 1..4, LSB first
cmd_expect_resp  in  1  1: collect response after frame
uart_tx_en  out  1  one-cycle pulse: send uart_tx_data
uart_tx_data  out  8  byte to transmit
uart_tx_busy  in  1  transmitter busy
uart_rx_valid  in  1  one-cycle pulse: uart_rx_data valid
uart_rx_data  in  8  received byte
resp_valid  out  1  one-cycle pulse: resp_data complete
resp_data  out  32  assembled response, unfilled upper bytes zero
resp_timeout  out  1  one-cycle pulse: response aborted
busy  out  1  state != IDLE

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE, byte_idx=0, rx_idx=0, timer=0; uart_tx_en, uart_tx_data, resp_valid, resp_data, resp_timeout all 0. cmd_ready=0 while resetn=0; cmd_ready=1 from the first clock after release. Reset mid-frame aborts silently; no partial pulses.
- cmd_ready = (state==IDLE) && resetn; busy = (state!=IDLE).
- States: IDLE, SEND, GAP, WAIT_RESP.
- IDLE: on accept, latch opcode, payload, and expect; set byte_idx=0; go to SEND.
- SEND: when uart_tx_busy=0, drive uart_tx_en=1 for exactly one cycle with uart_tx_data=frame[byte_idx] (frame[0]=opcode, frame[k]=payload[8k-1:8k-8]); go to GAP. While uart_tx_busy=1, hold in SEND with no pulse.
- GAP: exactly one cycle. This masks the busy-rise latency of the transmitter.
  - If byte_idx<4: increment byte_idx, go to SEND.
  - If byte_idx=4 and expect=1: go to WAIT_RESP with rx_idx=0, timer=0, resp_data cleared to 0.
  - Otherwise go to IDLE.
- Latency: with the transmitter idle, the first uart_tx_en occurs on the cycle after accept. Consecutive pulses are at least 2 cycles apart. Exactly 5 pulses per frame.
- WAIT_RESP:
  - On uart_rx_valid: write byte into resp_data[8*rx_idx+7:8*rx_idx], increment rx_idx, reset timer to 0.
  - When the RESP_BYTES-th byte is written: resp_valid=1 in the following cycle with the complete word, then go to IDLE.
  - With no byte, timer increments. When timer=TIMEOUT_CYCLES-1 without a byte: pulse resp_timeout for 1 cycle, resp_data keeps partial bytes, go to IDLE.
  - A byte arriving in the same cycle as expiry wins: it is stored and the timer reloads.
- uart_rx_valid outside WAIT_RESP is discarded with no side effect.
- resp_data holds its value until the next WAIT_RESP entry.
- resp_valid and resp_timeout are never asserted together. cmd_ready is 0 during their pulse cycle and returns to 1 on the next cycle.
- cmd_valid while busy is ignored; inputs are not sampled until acceptance.
- timer width: $clog2(TIMEOUT_CYCLES+1); no wrap is possible.

Test Plan:
- No-response frame: opcode=0x53, payload=0x11223344, expect=0, tx model with busy 3 cycles after each en. Required: uart_tx_data sequence 0x53,0x44,0x33,0x22,0x11; 5 en pulses; busy drops after the last GAP; no resp pulse.
- Response collect: expect=1, RESP_BYTES=4, rx bytes 0xEF,0xBE,0xAD,0xDE spaced 10 cycles apart. Required: single resp_valid with resp_data=0xDEADBEEF; cmd_ready=1 the next cycle.
- Timeout: TIMEOUT_CYCLES=16, expect=1, two rx bytes 0x01,0x02, then silence. Required: resp_timeout pulse exactly 16 cycles after the second byte; resp_data=0x00000201; no resp_valid.
- Backpressure and stray bytes: uart_tx_busy held 1 for 50 cycles after accept, rx byte 0xAA injected during SEND. Required: no en until busy falls; 0xAA discarded; later response is unaffected.
- Async reset mid-frame: assert resetn=0 between bytes 2 and 3 (no clock edge). Required: outputs 0 immediately; after release, a new command transmits its full 5-byte frame from byte 0.
- Expiry/byte collision: rx byte presented on the cycle timer=TIMEOUT_CYCLES-1. Required: byte stored, no resp_timeout, timer restarts.
